// File: rtl/dump_sequencer_if.sv
// Signal bundle between a display controller and dump_sequencer: sweep controls,
// the datapath snapshot inputs and the per-entry display outputs.
interface dump_sequencer_if;
  logic              start;
  logic              step;
  logic              auto_en;
  logic [31:0][11:0] registers;
  logic [31:0][11:0] memoria;
  logic [4:0]        index;
  logic              src;
  logic              neg;
  logic [3:0]        digit3;
  logic [3:0]        digit2;
  logic [3:0]        digit1;
  logic [3:0]        digit0;
  logic              digits_valid;
  logic              busy;
  logic              done;

  modport master (
    output start, step, auto_en, registers, memoria,
    input  index, src, neg, digit3, digit2, digit1, digit0, digits_valid, busy, done
  );

  modport slave (
    input  start, step, auto_en, registers, memoria,
    output index, src, neg, digit3, digit2, digit1, digit0, digits_valid, busy, done
  );
endinterface

// File: rtl/dump_sequencer.sv
// Sweeps the register file, then data memory, converting each 12-bit two's-complement
// word to a sign flag plus four BCD digits held for display until the next advance.
module dump_sequencer #(
  parameter int AUTO_TICKS = 16
) (
  input logic             clk,
  input logic             rst_n,
  dump_sequencer_if.slave bus
);

  localparam int DW = (AUTO_TICKS > 1) ? $clog2(AUTO_TICKS) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(AUTO_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CONVERT = 3'd2,
    SHOW    = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          start_q, start_d;
  logic          step_meta_q, step_meta_d;
  logic          step_sync_q, step_sync_d;
  logic          step_prev_q, step_prev_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [27:0]   dd_q, dd_d;
  logic [4:0]    index_q, index_d;
  logic          src_q, src_d;
  logic          neg_q, neg_d;
  logic [15:0]   bcd_q, bcd_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          step_evt_s;
  logic          advance_s;
  logic [11:0]   word_s;
  logic [27:0]   dd_step_s;

  function automatic logic [11:0] magnitude(input logic [11:0] w);
    logic [11:0] m;
    if (w[11]) begin
      m = ~w + 12'd1;
    end else begin
      m = w;
    end
    return m;
  endfunction

  // One double-dabble iteration: bump every BCD nibble >= 5 by 3, then shift in the next binary bit.
  function automatic logic [27:0] dabble_step(input logic [27:0] v);
    logic [27:0] t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      if (t[12 + 4*i +: 4] >= 4'd5) begin
        t[12 + 4*i +: 4] = t[12 + 4*i +: 4] + 4'd3;
      end else begin
        t[12 + 4*i +: 4] = t[12 + 4*i +: 4];
      end
    end
    return {t[26:0], 1'b0};
  endfunction

  // Next-state and next-output computation; start (registered) overrides everything else.
  always_comb begin
    state_d     = state_q;
    start_d     = bus.start;
    step_meta_d = bus.step;
    step_sync_d = step_meta_q;
    step_prev_d = step_sync_q;
    dwell_d     = dwell_q;
    bit_cnt_d   = bit_cnt_q;
    dd_d        = dd_q;
    index_d     = index_q;
    src_d       = src_q;
    neg_d       = neg_q;
    bcd_d       = bcd_q;
    step_evt_s  = step_sync_q & ~step_prev_q;
    advance_s   = step_evt_s | (bus.auto_en & (dwell_q == DWELL_LAST));
    word_s      = src_q ? bus.memoria[index_q] : bus.registers[index_q];
    dd_step_s   = dabble_step(dd_q);

    if (start_q) begin
      state_d = LOAD;
      index_d = 5'd0;
      src_d   = 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          neg_d     = word_s[11];
          dd_d      = {16'd0, magnitude(word_s)};
          bit_cnt_d = 4'd0;
          state_d   = CONVERT;
        end
        CONVERT: begin
          dd_d      = dd_step_s;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd11) begin
            state_d = SHOW;
            bcd_d   = dd_step_s[27:12];
            dwell_d = '0;
          end else begin
            state_d = CONVERT;
          end
        end
        SHOW: begin
          if (!advance_s) begin
            dwell_d = dwell_q + DW'(1);
          end else if (src_q && (index_q == 5'd31)) begin
            state_d = DONE;
          end else begin
            state_d = LOAD;
            index_d = index_q + 5'd1;
            src_d   = src_q | (index_q == 5'd31);
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    busy_d  = (state_d == LOAD) || (state_d == CONVERT) || (state_d == SHOW);
    done_d  = (state_d == DONE);
    valid_d = (state_d == SHOW);
  end

  // State, synchronizer, converter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      step_meta_q <= 1'b0;
      step_sync_q <= 1'b0;
      step_prev_q <= 1'b0;
      dwell_q     <= '0;
      bit_cnt_q   <= 4'd0;
      dd_q        <= 28'd0;
      index_q     <= 5'd0;
      src_q       <= 1'b0;
      neg_q       <= 1'b0;
      bcd_q       <= 16'd0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      step_meta_q <= step_meta_d;
      step_sync_q <= step_sync_d;
      step_prev_q <= step_prev_d;
      dwell_q     <= dwell_d;
      bit_cnt_q   <= bit_cnt_d;
      dd_q        <= dd_d;
      index_q     <= index_d;
      src_q       <= src_d;
      neg_q       <= neg_d;
      bcd_q       <= bcd_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.index        = index_q;
  assign bus.src          = src_q;
  assign bus.neg          = neg_q;
  assign bus.digit3       = bcd_q[15:12];
  assign bus.digit2       = bcd_q[11:8];
  assign bus.digit1       = bcd_q[7:4];
  assign bus.digit0       = bcd_q[3:0];
  assign bus.digits_valid = valid_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_dump_sequencer.sv
// Randomized scoreboard bench for dump_sequencer: stimulus queues the expected entry
// for every sweep position it triggers, a monitor checks each display window.
module tb_dump_sequencer;
  localparam int TICKS = 4;

  logic        clk;
  logic        rst_n;
  int          n_total;
  int          n_pass;
  bit          auto_mode;
  logic        prev_valid = 1'b0;
  int          win_len = 0;
  logic [22:0] exp_q[$];
  logic [22:0] last_exp;

  dump_sequencer_if bus ();

  dump_sequencer #(.AUTO_TICKS(TICKS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [22:0] obs();
    return {bus.index, bus.src, bus.neg, bus.digit3, bus.digit2, bus.digit1, bus.digit0};
  endfunction

  function automatic logic [25:0] status();
    return {obs(), bus.digits_valid, bus.busy, bus.done};
  endfunction

  function automatic logic [11:0] word_at(input int pos);
    return (pos < 32) ? bus.registers[5'(pos)] : bus.memoria[5'(pos - 32)];
  endfunction

  // Reference: signed value -> sign and decimal digits of its magnitude.
  function automatic logic [22:0] model(input int pos, input logic [11:0] w);
    int v;
    int m;
    v = int'(w);
    if (w[11]) v = v - 4096;
    m = (v < 0) ? -v : v;
    return {5'(pos % 32), (pos >= 32), (v < 0),
            4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic report_fail(input string name, input logic [31:0] act);
    n_total++;
    $display("FAIL %s: got %h, expected no display window", name, act);
  endtask

  task automatic press();
    bus.step = 1'b1;
    repeat (2) @(negedge clk);
    bus.step = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (bus.digits_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus.digits_valid), 32'd1);
  endtask

  // Monitor: every new display window must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.digits_valid === 1'b1 && prev_valid !== 1'b1) begin
      if (exp_q.size() == 0) begin
        report_fail("show_unexpected", 32'(obs()));
      end else begin
        check("show_entry", 32'(obs()), 32'(exp_q[0]));
        last_exp <= exp_q[0];
        exp_q.delete(0);
      end
      win_len <= 1;
    end else if (bus.digits_valid === 1'b1) begin
      win_len <= win_len + 1;
    end else if (prev_valid === 1'b1 && auto_mode) begin
      check("dwell_cycles", 32'(win_len), 32'(TICKS));
    end
    prev_valid <= bus.digits_valid;
  end

  initial begin
    int n;
    n_total   = 0;
    n_pass    = 0;
    auto_mode = 1'b0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.step  = 1'b0;
    bus.auto_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.registers[i] = 12'($urandom);
      bus.memoria[i]   = 12'($urandom);
    end
    bus.registers[0] = 12'd1234;
    bus.registers[1] = 12'hFFF;
    bus.registers[2] = 12'h800;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(status()), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_after_release", 32'(status()), 32'd0);

    // First entry and start-to-display latency.
    exp_q.push_back(model(0, word_at(0)));
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (12) @(posedge clk);
    @(posedge clk);
    #1 check("valid_before_latency", 32'(bus.digits_valid), 32'd0);
    @(posedge clk);
    #1 check("valid_at_latency", 32'(bus.digits_valid), 32'd1);
    check("busy_in_show", 32'(bus.busy), 32'd1);
    check("entry0_1234", 32'(obs()), 32'({5'd0, 1'b0, 1'b0, 16'h1234}));
    @(negedge clk);

    // Negative extremes via manual steps.
    exp_q.push_back(model(1, word_at(1)));
    press();
    wait_valid("show1_timeout");
    check("entry1_fff", 32'(obs()), 32'({5'd1, 1'b0, 1'b1, 16'h0001}));
    exp_q.push_back(model(2, word_at(2)));
    press();
    wait_valid("show2_timeout");
    check("entry2_800", 32'(obs()), 32'({5'd2, 1'b0, 1'b1, 16'h2048}));

    // Steps and a sub-cycle glitch during CONVERT, plus a data change after LOAD.
    exp_q.push_back(model(3, word_at(3)));
    press();
    bus.registers[3] = ~bus.registers[3];
    press();
    #2 bus.step = 1'b1;
    #2 bus.step = 1'b0;
    wait_valid("show3_timeout");
    repeat (10) @(negedge clk);
    check("no_step_queued", 32'({bus.src, bus.index, bus.digits_valid}), 32'({1'b0, 5'd3, 1'b1}));

    // Reset in the middle of converting index 7.
    for (int p = 4; p <= 6; p++) begin
      exp_q.push_back(model(p, word_at(p)));
      press();
      wait_valid("show_manual_timeout");
    end
    press();
    repeat (3) @(negedge clk);
    check("busy_before_abort", 32'({bus.busy, bus.index, bus.digits_valid}), 32'({1'b1, 5'd7, 1'b0}));
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_mid_convert", 32'(status()), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_no_partial", 32'(status()), 32'd0);
    exp_q.push_back(model(0, word_at(0)));
    pulse_start();
    wait_valid("restart_after_reset_timeout");

    // Full automatic sweep with fresh data.
    for (int i = 0; i < 32; i++) begin
      bus.registers[i] = 12'($urandom);
      bus.memoria[i]   = 12'($urandom);
    end
    for (int p = 0; p < 64; p++) exp_q.push_back(model(p, word_at(p)));
    bus.auto_en = 1'b1;
    pulse_start();
    repeat (2) @(negedge clk);
    auto_mode = 1'b1;
    n = 0;
    while (bus.done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("sweep_done", 32'({bus.done, bus.busy, bus.src, bus.index}), 32'({1'b1, 1'b0, 1'b1, 5'd31}));
    check("done_holds_last", 32'(obs()), 32'(last_exp));
    check("sweep_all_shown", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    auto_mode = 1'b0;
    bus.auto_en = 1'b0;

    // Walk to src=1, index=10, then start and a step event in the same cycle.
    exp_q.push_back(model(0, word_at(0)));
    pulse_start();
    wait_valid("show_walk_start_timeout");
    for (int p = 1; p <= 42; p++) begin
      exp_q.push_back(model(p, word_at(p)));
      press();
      wait_valid("show_walk_timeout");
    end
    check("at_src1_idx10", 32'({bus.src, bus.index}), 32'({1'b1, 5'd10}));
    exp_q.push_back(model(0, word_at(0)));
    bus.step = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.step = 1'b0;
    wait_valid("restart_timeout");
    repeat (10) @(negedge clk);
    check("restart_step_ignored", 32'({bus.src, bus.index, bus.digits_valid}), 32'({1'b0, 5'd0, 1'b1}));
    check("restart_all_shown", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/dump_sequencer.md
DUMP_SEQUENCER -- requirements
Module: dump_sequencer

Interface
REQ-001 Parameter AUTO_TICKS, default 16, SHALL set the SHOW dwell in clock cycles when auto-advance is enabled.
REQ-002 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low; SHALL force every register to its reset value while low.
REQ-004 start  input  1  synchronous pulse that begins a dump sweep.
REQ-005 step  input  1  raw push-button level, asynchronous to clock.
REQ-006 auto_en  input  1  1 = advance automatically after AUTO_TICKS cycles; 0 = advance on step.
REQ-007 Registers  input  [31:0][11:0]  register-file contents, consumed from the datapath.
REQ-008 Memoria  input  [31:0][11:0]  data-memory contents, consumed from the datapath.
REQ-009 index  output  5  entry currently shown.
REQ-010 src  output  1  0 = register entry, 1 = memory entry.
REQ-011 neg  output  1  1 when the captured value is negative in two's complement.
REQ-012 digit3..digit0  output  4 each  BCD magnitude, thousands to units.
REQ-013 digits_valid  output  1  digits and neg are stable and belong to index/src.
REQ-014 busy  output  1  sweep in progress.
REQ-015 done  output  1  sweep complete.

Function
REQ-016 States SHALL be IDLE, LOAD, CONVERT, SHOW and DONE.
REQ-017 The sweep SHALL cover 64 entries: src=0 with index 0..31, then src=1 with index 0..31.
REQ-018 The step input SHALL pass through a 2-flop synchronizer; a rising edge of the synchronized signal is a step event.
REQ-019 IDLE/DONE + start=1 SHALL move to LOAD with index=0, src=0 and done=0.
REQ-020 LOAD SHALL take one cycle: snapshot the selected 12-bit word, set neg=word[11], form magnitude = word[11] ? (~word+1) : word as 12-bit unsigned (12'h800 -> 2048), then enter CONVERT.
REQ-021 CONVERT SHALL run double-dabble shift-add-3 for exactly 12 cycles, then enter SHOW.
REQ-022 In SHOW, digits_valid SHALL be 1; it SHALL be 0 in all other states.
REQ-023 Latency: start sampled at edge k SHALL give digits_valid=1 after edge k+14 (1 cycle in LOAD, 12 in CONVERT).
REQ-024 SHOW with auto_en=0 SHALL advance on a step event.
REQ-025 SHOW with auto_en=1 SHALL advance after AUTO_TICKS cycles in SHOW; step events SHALL also advance. The dwell counter SHALL clear on every SHOW entry.
REQ-026 Advance from SHOW SHALL increment index. If index was 31 with src=0, index SHALL wrap to 0 and src SHALL become 1. The next state SHALL be LOAD.
REQ-027 Advance from src=1, index=31 SHALL go to DONE. done SHALL be 1 in DONE. index, src and digits SHALL hold their last values.
REQ-028 busy SHALL be 1 in LOAD, CONVERT and SHOW.
REQ-029 Step events during LOAD or CONVERT SHALL be discarded and not queued.
REQ-030 start while busy SHALL restart the sweep at LOAD with index=0, src=0. start has priority over a simultaneous step or dwell expiry.
REQ-031 Registers and Memoria SHALL be sampled only in LOAD. Changes during CONVERT or SHOW SHALL NOT alter the displayed digits.

Reset
REQ-032 When reset is low, the block SHALL enter IDLE with index=0, src=0, neg=0, all digits=0, digits_valid=0, busy=0 and done=0. The synchronizer, dwell counter and conversion shift register SHALL be cleared.
REQ-033 Reset low during any state, including mid-CONVERT, SHALL abort immediately. No partial digits SHALL remain after release.
REQ-034 After reset release, the block SHALL stay in IDLE until start.

Verification
REQ-035 Registers[0]=12'd1234, start, auto_en=0 -> after 14 cycles: digits 1,2,3,4, neg=0, src=0, index=0, digits_valid=1.
REQ-036 Registers[1]=12'hFFF, then Registers[2]=12'h800, with step events -> index1: neg=1, digits 0,0,0,1; index2: neg=1, digits 2,0,4,8.
REQ-037 Full sweep with auto_en=1, AUTO_TICKS=4, distinct values -> 64 SHOW windows of 4 cycles each; src flips after the 32nd; done=1 and busy=0 after the 64th.
REQ-038 Step pulses during CONVERT plus a step glitch shorter than one clock -> no index change.
REQ-039 Reset low mid-CONVERT at index 7 -> all outputs at reset values; after release and start, the sweep begins at index 0.
REQ-040 start asserted during SHOW at src=1, index=10, in the same cycle as a step event -> restart at index 0, src=0; the step event is ignored.
